// File: rtl/neo_pkg.sv
// Shared types and default widths for the NEO spike detector.
// Optional feature macro: NEO_REFRACTORY_EN (see neo_spike_detector.sv).
package neo_pkg;
  typedef enum logic [2:0] {IDLE, ACCUM, THRESH, SCAN, HOLD, DONE} state_t;

  localparam int P_N        = 8;
  localparam int P_M        = 16;
  localparam int P_THR_MULT = 4;
  localparam int P_REFRACT  = 3;

  localparam int AW   = $clog2(P_M) + 1;
  localparam int SUMW = P_N + $clog2(P_M);
  localparam int THRW = P_N + $clog2(P_THR_MULT) + 1;
endpackage

// File: rtl/neo_threshold_calc.sv
// Turns the accumulated clamped sum into the spike threshold: (sum >> log2(M)) * THR_MULT,
// registered on load so the scan sees a stable threshold.
module neo_threshold_calc #(
  parameter int N        = 8,
  parameter int M        = 16,
  parameter int THR_MULT = 4
) (
  input  logic                                 Clk,
  input  logic                                 reset,
  input  logic                                 load,
  input  logic [N+$clog2(M)-1:0]               sum,
  output logic [N+$clog2(THR_MULT):0]          thr
);
  localparam int LG    = $clog2(M);
  localparam int TW    = N + $clog2(THR_MULT) + 1;
  localparam logic [TW-1:0] MULT = TW'(THR_MULT);

  logic [TW-1:0] mean;
  assign mean = TW'(sum >> LG);

  always_ff @(posedge Clk) begin
    if (reset)     thr <= '0;
    else if (load) thr <= mean * MULT;
  end
endmodule

// File: rtl/neo_spike_detector.sv
// Two-pass NEO reader: accumulates clamped samples into an adaptive threshold, then rescans
// and emits a valid/ready event per sample above it. NEO_REFRACTORY_EN adds a post-spike dead time.
module neo_spike_detector
  import neo_pkg::*;
#(
  parameter int N        = P_N,
  parameter int M        = P_M,
  parameter int THR_MULT = P_THR_MULT,
  parameter int REFRACT  = P_REFRACT
) (
  input  logic                    Clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic signed [N-1:0]     rdata,
  output logic [$clog2(M):0]      raddr,
  output logic                    spike_valid,
  input  logic                    spike_ready,
  output logic [$clog2(M):0]      spike_addr,
  output logic signed [N-1:0]     spike_value,
  output logic                    busy,
  output logic                    done
);
  localparam int LG  = $clog2(M);
  localparam int AWL = LG + 1;
  localparam int SW  = N + LG;
  localparam int TW  = N + $clog2(THR_MULT) + 1;

  state_t         state;
  logic [AWL-1:0] idx;
  logic [SW-1:0]  sum;
  logic [TW-1:0]  thr;
  logic [SW-1:0]  pos;
  logic           last, above, quiet, fire;

  assign raddr = idx;
  assign last  = (idx == AWL'(M - 1));
  assign pos   = rdata[N-1] ? '0 : {{LG{1'b0}}, rdata};
  // thr is never negative, so a zero-extended thr against sign-extended rdata is exact
  assign above = $signed({{(TW + 1 - N){rdata[N-1]}}, rdata}) > $signed({1'b0, thr});
  assign fire  = quiet && above;

  neo_threshold_calc #(.N(N), .M(M), .THR_MULT(THR_MULT)) u_thr (
    .Clk   (Clk),
    .reset (reset),
    .load  (state == THRESH),
    .sum   (sum),
    .thr   (thr)
  );

`ifdef NEO_REFRACTORY_EN
  localparam int RW = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;
  logic [RW-1:0] refr;
  assign quiet = (refr == '0);

  always_ff @(posedge Clk) begin
    if (reset)                                      refr <= '0;
    else if (state == IDLE && start)                refr <= '0;
    else if (state == HOLD && spike_ready)          refr <= RW'(REFRACT);
    else if (state == SCAN && !fire && refr != '0)  refr <= refr - 1'b1;
  end
`else
  assign quiet = 1'b1;
`endif

  always_ff @(posedge Clk) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      sum         <= '0;
      spike_valid <= 1'b0;
      spike_addr  <= '0;
      spike_value <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= ACCUM;
          idx   <= '0;
          sum   <= '0;
          busy  <= 1'b1;
        end
        ACCUM: begin
          sum <= sum + pos;
          if (last) begin
            idx   <= '0;
            state <= THRESH;
          end else idx <= idx + 1'b1;
        end
        THRESH: begin
          idx   <= '0;
          state <= SCAN;
        end
        SCAN: begin
          if (fire) begin
            spike_valid <= 1'b1;
            spike_addr  <= idx;
            spike_value <= rdata;
            state       <= HOLD;
          end else if (last) begin
            idx   <= '0;
            done  <= 1'b1;
            state <= DONE;
          end else idx <= idx + 1'b1;
        end
        HOLD: if (spike_ready) begin
          spike_valid <= 1'b0;
          if (last) begin
            idx   <= '0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx   <= idx + 1'b1;
            state <= SCAN;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_neo_spike_detector.sv
// Directed bench for neo_spike_detector with a reference model and event scoreboard.
module tb_neo_spike_detector;
  logic              Clk = 1'b0;
  logic              reset, start, spike_ready;
  logic signed [7:0] rdata;
  logic [4:0]        raddr, spike_addr;
  logic              spike_valid, busy, done;
  logic signed [7:0] spike_value;

  logic signed [7:0] mem [16];
  int exp_addr[$];
  int exp_val[$];
  int checks = 0;
  int passed = 0;

  assign rdata = mem[raddr[3:0]];
  always #5 Clk = ~Clk;

  neo_spike_detector dut (
    .Clk(Clk), .reset(reset), .start(start), .rdata(rdata), .raddr(raddr),
    .spike_valid(spike_valid), .spike_ready(spike_ready), .spike_addr(spike_addr),
    .spike_value(spike_value), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int build_model();
    int s, thr, refr, n;
    s = 0; refr = 0; n = 0;
    exp_addr.delete(); exp_val.delete();
    for (int i = 0; i < 16; i++) if (mem[i] > 0) s += int'(mem[i]);
    thr = (s >> 4) * 4;
    for (int i = 0; i < 16; i++) begin
      if (refr > 0) refr--;
      else if (int'(mem[i]) > thr) begin
        exp_addr.push_back(i);
        exp_val.push_back(int'(mem[i]));
        n++;
`ifdef NEO_REFRACTORY_EN
        refr = 3;
`else
        refr = 0;
`endif
      end
    end
    return n;
  endfunction

  task automatic fill(input int v);
    for (int i = 0; i < 16; i++) mem[i] = 8'(v);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, " raddr"}, 32'(raddr), 0);
    chk({tag, " valid"}, 32'(spike_valid), 0);
    chk({tag, " saddr"}, 32'(spike_addr), 0);
    chk({tag, " svalue"}, 32'(spike_value), 0);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " done"}, 32'(done), 0);
  endtask

  task automatic run_pass(input string tag, input int stall);
    int nev, exp_done, cyc, st;
    bit holding, seen;
    logic [4:0] ha;
    logic signed [7:0] hv;
    nev = build_model();
    exp_done = 34 + nev + ((nev > 0) ? stall : 0);
    st = stall; holding = 0; seen = 0; cyc = 0;
    spike_ready = 1'b1;
    @(negedge Clk) start = 1'b1;
    @(posedge Clk); #1 start = 1'b0;
    while (!seen && cyc < 200) begin
      cyc++;
      chk({tag, " busy"}, 32'(busy), 1);
      if (spike_valid) begin
        if (!holding) begin
          holding = 1;
          ha = spike_addr; hv = spike_value;
          if (exp_addr.size() == 0) chk({tag, " extra spike"}, 32'(spike_addr), -1);
          else begin
            chk({tag, " spike addr"}, 32'(spike_addr), exp_addr.pop_front());
            chk({tag, " spike value"}, 32'(spike_value), exp_val.pop_front());
          end
        end else begin
          chk({tag, " hold addr"}, 32'(spike_addr), 32'(ha));
          chk({tag, " hold value"}, 32'(spike_value), 32'(hv));
          if (st > 0) st--;
        end
        spike_ready = (st == 0);
      end else begin
        holding = 0;
        spike_ready = 1'b1;
      end
      if (done) begin
        chk({tag, " done cycle"}, cyc, exp_done);
        seen = 1;
      end else begin
        @(posedge Clk); #1;
      end
    end
    if (!seen) chk({tag, " done timeout"}, 0, 1);
    spike_ready = 1'b1;
    @(posedge Clk); #1;
    chk({tag, " busy after"}, 32'(busy), 0);
    chk({tag, " done pulse"}, 32'(done), 0);
    chk({tag, " valid after"}, 32'(spike_valid), 0);
    chk({tag, " events left"}, exp_addr.size(), 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; spike_ready = 1'b1;
    fill(0);
    repeat (3) @(posedge Clk);
    #1 check_idle("reset");
    @(negedge Clk) reset = 1'b0;

    fill(2);
    run_pass("c1 flat", 0);

    fill(1); mem[5] = 8'sd100;
    run_pass("c2 one spike", 0);
    run_pass("c3 stall", 5);

    fill(-3); mem[0] = 8'sd10;
    run_pass("c4 negatives", 0);

    fill(0);
    run_pass("c0 zeros", 0);

    // reset lands on the third SCAN cycle (cycle 20 after the start edge)
    fill(2);
    @(negedge Clk) start = 1'b1;
    @(posedge Clk); #1 start = 1'b0;
    for (int c = 1; c < 20; c++) begin @(posedge Clk); #1; end
    chk("c5 busy pre", 32'(busy), 1);
    reset = 1'b1;
    @(posedge Clk); #1;
    check_idle("c5 mid reset");
    reset = 1'b0;
    run_pass("c5 rerun", 0);

    fill(1); mem[4] = 8'sd100; mem[5] = 8'sd100; mem[8] = 8'sd100;
    run_pass("c6 burst", 0);

    fill(1); mem[15] = 8'sd90; mem[14] = 8'sd90;
    run_pass("last idx", 2);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 16; i++) mem[i] = 8'($urandom_range(0, 255));
      run_pass("random", int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
